// File: rtl/bus_copy_initiator_pkg.sv
// Shared femto bus definitions plus the encodings used by the copy initiator.
// Bus geometry, access-size codes, copy error codes and FSM states live here.
package bus_copy_initiator_pkg;

   localparam int XLEN        = 32;
   localparam int BUS_WIDTH   = 32;
   localparam int BUS_ACC_CNT = 3;
   localparam int ACC_W       = $clog2(BUS_ACC_CNT);

   localparam logic [ACC_W-1:0] ACC_1B = ACC_W'(0);
   localparam logic [ACC_W-1:0] ACC_2B = ACC_W'(1);
   localparam logic [ACC_W-1:0] ACC_4B = ACC_W'(2);

   typedef enum logic [1:0] {
      COPY_ERR_NONE    = 2'd0,
      COPY_ERR_FAULT   = 2'd1,
      COPY_ERR_TIMEOUT = 2'd2,
      COPY_ERR_ABORT   = 2'd3
   } copy_err_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR_REQ,
      ST_WR_WAIT
   } copy_state_e;

   function automatic logic [XLEN-1:0] unit_bytes(input logic [ACC_W-1:0] acc);
      case (acc)
         ACC_4B:  return XLEN'(4);
         ACC_2B:  return XLEN'(2);
         default: return XLEN'(1);
      endcase
   endfunction

endpackage

// File: rtl/bus_copy_initiator.sv
// Femto bus master that copies len bytes from src_addr to dst_addr as read/write pairs.
// Word accesses are used only when source, destination and length are all word aligned.
module bus_copy_initiator
   import bus_copy_initiator_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [XLEN-1:0]      src_addr,
   input  logic [XLEN-1:0]      dst_addr,
   input  logic [LEN_W-1:0]     len,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [XLEN-1:0]      err_addr,
   output logic [XLEN-1:0]      addr,
   output logic                 w_rb,
   output logic [ACC_W-1:0]     acc,
   output logic [BUS_WIDTH-1:0] wdata,
   input  logic [BUS_WIDTH-1:0] rdata,
   output logic                 req,
   input  logic                 resp,
   input  logic                 fault
);

   localparam int               TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   copy_state_e          state_q, state_n;
   logic [LEN_W-1:0]     rem_q;
   logic [XLEN-1:0]      src_q, dst_q;
   logic [BUS_WIDTH-1:0] buf_q;
   logic [ACC_W-1:0]     acc_q;
   logic [TMO_W-1:0]     tmo_q;
   logic                 abort_q;
   logic                 done_q, err_q;
   copy_err_e            err_code_q, err_code_n;
   logic [XLEN-1:0]      err_addr_q, err_addr_n;

   logic                 abort_now;
   logic                 req_c;
   logic                 fin_done, fin_err;
   logic                 aligned;
   logic [XLEN-1:0]      step;
   logic [LEN_W-1:0]     step_len;
   logic                 last_unit;

   assign abort_now = abort_q | abort;
   assign aligned   = (src_addr[1:0] == 2'b00) && (dst_addr[1:0] == 2'b00) && (len[1:0] == 2'b00);
   assign step      = unit_bytes(acc_q);
   assign step_len  = LEN_W'(step);
   assign last_unit = (rem_q == step_len);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_n    = state_q;
      req_c      = 1'b0;
      fin_done   = 1'b0;
      fin_err    = 1'b0;
      err_code_n = err_code_q;
      err_addr_n = err_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_n    = ST_RD_REQ;
               err_code_n = COPY_ERR_NONE;
               err_addr_n = '0;
            end
         end
         ST_RD_REQ: begin
            if (rem_q == '0) begin
               state_n  = ST_IDLE;
               fin_done = 1'b1;
            end else if (abort_now) begin
               state_n    = ST_IDLE;
               fin_err    = 1'b1;
               err_code_n = COPY_ERR_ABORT;
               err_addr_n = src_q;
            end else begin
               req_c = 1'b1;
               if (fault) begin
                  state_n    = ST_IDLE;
                  fin_err    = 1'b1;
                  err_code_n = COPY_ERR_FAULT;
                  err_addr_n = src_q;
               end else begin
                  state_n = ST_RD_WAIT;
               end
            end
         end
         ST_RD_WAIT: begin
            // A pending abort is honoured only once the outstanding read has completed.
            if (resp) begin
               if (abort_now) begin
                  state_n    = ST_IDLE;
                  fin_err    = 1'b1;
                  err_code_n = COPY_ERR_ABORT;
                  err_addr_n = dst_q;
               end else begin
                  state_n = ST_WR_REQ;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_n    = ST_IDLE;
               fin_err    = 1'b1;
               err_code_n = COPY_ERR_TIMEOUT;
               err_addr_n = src_q;
            end
         end
         ST_WR_REQ: begin
            if (abort_now) begin
               state_n    = ST_IDLE;
               fin_err    = 1'b1;
               err_code_n = COPY_ERR_ABORT;
               err_addr_n = dst_q;
            end else begin
               req_c = 1'b1;
               if (fault) begin
                  state_n    = ST_IDLE;
                  fin_err    = 1'b1;
                  err_code_n = COPY_ERR_FAULT;
                  err_addr_n = dst_q;
               end else begin
                  state_n = ST_WR_WAIT;
               end
            end
         end
         ST_WR_WAIT: begin
            // Finishing the last unit beats a coincident abort; src_q already points at the next read.
            if (resp) begin
               if (last_unit) begin
                  state_n  = ST_IDLE;
                  fin_done = 1'b1;
               end else if (abort_now) begin
                  state_n    = ST_IDLE;
                  fin_err    = 1'b1;
                  err_code_n = COPY_ERR_ABORT;
                  err_addr_n = src_q;
               end else begin
                  state_n = ST_RD_REQ;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_n    = ST_IDLE;
               fin_err    = 1'b1;
               err_code_n = COPY_ERR_TIMEOUT;
               err_addr_n = dst_q;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         // NOTE: the data buffer is reset too, so wdata never carries stale data after reset.
         buf_q      <= '0;
         acc_q      <= ACC_1B;
         tmo_q      <= '0;
         abort_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= COPY_ERR_NONE;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_n;
         done_q     <= fin_done;
         err_q      <= fin_err;
         err_code_q <= err_code_n;
         err_addr_q <= err_addr_n;

         if (req_c) begin
            tmo_q <= '0;
         end else if (state_q == ST_RD_WAIT || state_q == ST_WR_WAIT) begin
            tmo_q <= tmo_q + TMO_W'(1);
         end

         if (state_q == ST_IDLE && start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            rem_q   <= len;
            acc_q   <= aligned ? ACC_4B : ACC_1B;
            abort_q <= abort;
         end else begin
            abort_q <= (state_n != ST_IDLE) && abort_now;
            if (state_q == ST_RD_WAIT && resp) begin
               buf_q <= rdata;
               src_q <= src_q + step;
            end
            if (state_q == ST_WR_WAIT && resp) begin
               dst_q <= dst_q + step;
               rem_q <= rem_q - step_len;
            end
         end
      end
   end

   // Bus fields are pure functions of state and held registers, hence stable from req to resp.
   always_comb begin
      addr = '0;
      case (state_q)
         ST_RD_REQ, ST_RD_WAIT: addr = src_q;
         ST_WR_REQ, ST_WR_WAIT: addr = dst_q;
         default:               addr = '0;
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign w_rb     = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT);
   assign acc      = busy ? acc_q : ACC_1B;
   assign wdata    = w_rb ? buf_q : '0;
   assign req      = req_c;
   assign done     = done_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_bus_copy_initiator.sv
// Directed bench for bus_copy_initiator: a scripted femto slave logs every request and the
// expected transaction list, end cycle and error fields are computed here and compared.
module tb_bus_copy_initiator;
   import bus_copy_initiator_pkg::*;

   localparam int LEN_W   = 16;
   localparam int TIMEOUT = 255;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic [XLEN-1:0]      src_addr = '0;
   logic [XLEN-1:0]      dst_addr = '0;
   logic [LEN_W-1:0]     len = '0;
   logic                 busy, done, err, w_rb, req;
   logic [1:0]           err_code;
   logic [XLEN-1:0]      err_addr, addr;
   logic [ACC_W-1:0]     acc;
   logic [BUS_WIDTH-1:0] wdata;
   logic [BUS_WIDTH-1:0] rdata = '0;
   logic                 resp = 1'b0;
   logic                 fault = 1'b0;

   bus_copy_initiator #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .err(err), .err_code(err_code), .err_addr(err_addr),
      .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata), .rdata(rdata),
      .req(req), .resp(resp), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic                 w;
      logic [XLEN-1:0]      a;
      logic [ACC_W-1:0]     acc;
      logic [BUS_WIDTH-1:0] d;
   } txn_t;

   txn_t       exp_q[$];
   txn_t       obs_q[$];
   logic [7:0] wmem [logic [XLEN-1:0]];

   int              total = 0;
   int              bad = 0;
   int              cyc = 0;
   int              obs_base = 0;
   int              lat = 1;
   bit              withhold = 1'b0;
   bit              flt_en = 1'b0;
   logic [XLEN-1:0] flt_addr = '0;
   logic            flt_w = 1'b0;

   function automatic logic [7:0] src_byte(input logic [XLEN-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [BUS_WIDTH-1:0] rd_word(input logic [XLEN-1:0] a, input logic [ACC_W-1:0] ac);
      if (ac == ACC_4B)
         return {src_byte(a + 32'd3), src_byte(a + 32'd2), src_byte(a + 32'd1), src_byte(a)};
      return {24'h0, src_byte(a)};
   endfunction

   // Responder: resp arrives lat cycles after the req cycle; reads come from src_byte().
   initial begin : slave
      bit                   pend;
      int                   cnt;
      logic [XLEN-1:0]      p_addr;
      logic [ACC_W-1:0]     p_acc;
      logic                 p_w;
      txn_t                 t;
      pend = 1'b0;
      cnt = 0;
      p_addr = '0;
      p_acc = ACC_1B;
      p_w = 1'b0;
      forever begin
         @(negedge clk);
         resp = 1'b0;
         fault = 1'b0;
         rdata = '0;
         if (rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               if (cnt == 0) begin
                  resp = 1'b1;
                  pend = 1'b0;
                  if (!p_w) rdata = rd_word(p_addr, p_acc);
               end else begin
                  cnt--;
               end
            end
            if (req) begin
               t.w = w_rb;
               t.a = addr;
               t.acc = acc;
               t.d = w_rb ? wdata : '0;
               obs_q.push_back(t);
               if (flt_en && addr == flt_addr && w_rb == flt_w) begin
                  fault = 1'b1;
               end else begin
                  if (w_rb) begin
                     if (acc == ACC_4B) begin
                        for (int b = 0; b < 4; b++) wmem[addr + XLEN'(b)] = wdata[8*b +: 8];
                     end else begin
                        wmem[addr] = wdata[7:0];
                     end
                  end
                  if (!withhold) begin
                     pend = 1'b1;
                     cnt = lat - 1;
                     p_addr = addr;
                     p_acc = acc;
                     p_w = w_rb;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_rd(input logic [XLEN-1:0] s, input logic [ACC_W-1:0] ac);
      txn_t t;
      t.w = 1'b0; t.a = s; t.acc = ac; t.d = '0;
      exp_q.push_back(t);
   endtask

   task automatic push_wr(input logic [XLEN-1:0] s, input logic [XLEN-1:0] d, input logic [ACC_W-1:0] ac);
      txn_t t;
      t.w = 1'b1; t.a = d; t.acc = ac; t.d = rd_word(s, ac);
      exp_q.push_back(t);
   endtask

   task automatic push_copy(input logic [XLEN-1:0] s, input logic [XLEN-1:0] d, input int n,
                            input logic [ACC_W-1:0] ac);
      int u;
      u = (ac == ACC_4B) ? 4 : 1;
      for (int i = 0; i < n; i += u) begin
         push_rd(s + XLEN'(i), ac);
         push_wr(s + XLEN'(i), d + XLEN'(i), ac);
      end
   endtask

   task automatic compare_txns(input string tag);
      int n;
      n = obs_q.size() - obs_base;
      check({tag, "_count"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         check($sformatf("%s_txn%0d", tag, i), obs_q[obs_base + i], exp_q[i]);
      exp_q.delete();
   endtask

   task automatic start_copy(input logic [XLEN-1:0] s, input logic [XLEN-1:0] d,
                             input logic [LEN_W-1:0] n, input logic ab);
      obs_base = obs_q.size();
      src_addr = s;
      dst_addr = d;
      len = n;
      start = 1'b1;
      abort = ab;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      cyc = 1;
   endtask

   // Waits (bounded) for done/err, then checks end cycle, outcome, held fields and pulse width.
   task automatic finish(input string tag, input int budget, input int exp_cyc, input logic exp_done,
                         input logic [1:0] exp_code, input logic [XLEN-1:0] exp_addr);
      int ec;
      ec = -1;
      for (int i = 0; i < budget; i++) begin
         if (done || err) begin
            ec = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      check({tag, "_end_seen"}, done | err, 1'b1);
      check({tag, "_end_cycle"}, ec, exp_cyc);
      check({tag, "_done_err"}, {done, err}, {exp_done, ~exp_done});
      check({tag, "_busy_low"}, busy, 1'b0);
      check({tag, "_err_code"}, err_code, exp_code);
      if (!exp_done) check({tag, "_err_addr"}, err_addr, exp_addr);
      @(negedge clk);
      cyc++;
      check({tag, "_pulse"}, {done, err}, 2'b00);
   endtask

   task automatic check_mem(input string tag, input logic [XLEN-1:0] s, input logic [XLEN-1:0] d, input int n);
      for (int i = 0; i < n; i++)
         check($sformatf("%s_mem%0d", tag, i), wmem[d + XLEN'(i)], src_byte(s + XLEN'(i)));
   endtask

   initial begin : stim
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, err, req, w_rb, acc, err_code, addr, wdata, err_addr}, '0);
      rst = 1'b0;
      @(negedge clk);

      // Aligned word copy, zero-wait slave: 2 units of 4 cycles.
      start_copy(32'h0, 32'h1000_0000, 16'd8, 1'b0);
      check("w4_first_req", {req, w_rb, addr, acc}, {1'b1, 1'b0, 32'h0, ACC_4B});
      push_copy(32'h0, 32'h1000_0000, 8, ACC_4B);
      finish("w4", 50, 9, 1'b1, COPY_ERR_NONE, '0);
      compare_txns("w4");
      check_mem("w4", 32'h0, 32'h1000_0000, 8);

      // Unaligned source: byte accesses for the whole copy.
      start_copy(32'h3, 32'h1000_0100, 16'd3, 1'b0);
      push_copy(32'h3, 32'h1000_0100, 3, ACC_1B);
      finish("b1", 50, 13, 1'b1, COPY_ERR_NONE, '0);
      compare_txns("b1");
      check_mem("b1", 32'h3, 32'h1000_0100, 3);

      // Fault on the second write: no traffic after the rejected request.
      flt_en = 1'b1; flt_addr = 32'h1000_0204; flt_w = 1'b1;
      start_copy(32'h40, 32'h1000_0200, 16'd12, 1'b0);
      push_copy(32'h40, 32'h1000_0200, 4, ACC_4B);
      push_rd(32'h44, ACC_4B);
      push_wr(32'h44, 32'h1000_0204, ACC_4B);
      finish("fault", 50, 8, 1'b0, COPY_ERR_FAULT, 32'h1000_0204);
      repeat (4) @(negedge clk);
      compare_txns("fault");
      flt_en = 1'b0;

      // Slave never answers the first read.
      withhold = 1'b1;
      start_copy(32'h80, 32'h1000_0300, 16'd4, 1'b0);
      push_rd(32'h80, ACC_4B);
      finish("tmo", 400, 1 + TIMEOUT + 1, 1'b0, COPY_ERR_TIMEOUT, 32'h80);
      compare_txns("tmo");
      withhold = 1'b0;

      // Abort during RD_WAIT with 3-cycle latency; a start while busy is ignored.
      lat = 3;
      start_copy(32'h100, 32'h2000, 16'd8, 1'b0);
      @(negedge clk);
      cyc++;
      abort = 1'b1;
      start = 1'b1;
      src_addr = 32'h5000;
      @(negedge clk);
      cyc++;
      abort = 1'b0;
      start = 1'b0;
      push_rd(32'h100, ACC_4B);
      finish("abort", 50, 5, 1'b0, COPY_ERR_ABORT, 32'h2000);
      compare_txns("abort");
      lat = 1;

      // Abort while idle does nothing; error fields stay held.
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_abort", {busy, err, done, err_code, err_addr}, {3'b000, COPY_ERR_ABORT, 32'h2000});

      // Start and abort together: start wins, abort taken before the first request.
      start_copy(32'h300, 32'h4000, 16'd4, 1'b1);
      finish("start_abort", 20, 2, 1'b0, COPY_ERR_ABORT, 32'h300);
      compare_txns("start_abort");

      // Zero length: one busy cycle, no bus traffic.
      start_copy(32'h10, 32'h20, 16'd0, 1'b0);
      check("len0_busy", {busy, req}, 2'b10);
      finish("len0", 20, 2, 1'b1, COPY_ERR_NONE, '0);
      compare_txns("len0");

      // Source address wraps past the top of the address space.
      start_copy(32'hFFFF_FFFC, 32'h0000_0010, 16'd8, 1'b0);
      push_copy(32'hFFFF_FFFC, 32'h10, 8, ACC_4B);
      finish("wrap", 50, 9, 1'b1, COPY_ERR_NONE, '0);
      compare_txns("wrap");

      // Reset in the middle of a copy, then a fresh copy.
      start_copy(32'h200, 32'h3000, 16'd64, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid", {busy, done, err, req, w_rb, acc, err_code, addr, wdata, err_addr}, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_copy(32'h400, 32'h5000, 16'd4, 1'b0);
      push_copy(32'h400, 32'h5000, 4, ACC_4B);
      finish("after_rst", 50, 5, 1'b1, COPY_ERR_NONE, '0);
      compare_txns("after_rst");
      check_mem("after_rst", 32'h400, 32'h5000, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
